// File: rtl/muldiv_if.sv
// muldiv_if
//   Request/response bundle between the EX stage and the iterative
//   multiply/divide unit.
//
//   Signals (directions as seen by the unit, slave modport):
//     start_i    in   request, held high with stable operands until ready_o
//     op_i       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     src1_i     in   multiplicand / dividend
//     src2_i     in   multiplier / divisor
//     annul_i    in   abort the operation in flight
//     busy_o     out  unit is iterating or fixing up signs
//     ready_o    out  one-cycle pulse, result_o valid
//     stallreq_o out  start_i & ~ready_o
//     result_o   out  MUL: product, DIV: {remainder, quotient}
//
//   Modports: master (EX stage), slave (muldiv_iter).
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     src1_i;
    logic [WIDTH-1:0]     src2_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ready_o;
    logic                 stallreq_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, annul_i,
        input  busy_o, ready_o, stallreq_o, result_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, annul_i,
        output busy_o, ready_o, stallreq_o, result_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter
//   Iterative radix-2 multiply/divide unit for the EX stage. Signed and
//   unsigned MUL (shift-add) and DIV (restoring shift-subtract) share one
//   set of registers. Operands are reduced to magnitudes on entry and the
//   sign is restored in a separate FIX cycle.
//
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   muldiv_if.slave: start_i, op_i, src1_i, src2_i, annul_i,
//           busy_o, ready_o, stallreq_o, result_o
//
//   Parameters:
//     WIDTH  operand width (result is 2*WIDTH)
//     CNT_W  iteration counter width, 2**CNT_W > WIDTH
//
//   Configuration macro:
//     MULDIV_EARLY_OUT_EN  when defined, MUL/MULTU leave the iteration as
//                          soon as the remaining multiplier is zero.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    // MUL: running product. DIV: {partial remainder, dividend/quotient shifter}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // MUL only: multiplicand shifted left one place per step.
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    // MUL: remaining multiplier magnitude. DIV: divisor magnitude.
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 op_signed;
    logic                 src1_neg;
    logic                 src2_neg;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;

    logic [WIDTH:0]       div_shifted;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic                 mul_early;

    assign op_signed = ~bus.op_i[0];
    assign src1_neg  = op_signed & bus.src1_i[WIDTH-1];
    assign src2_neg  = op_signed & bus.src2_i[WIDTH-1];
    assign mag1      = src1_neg ? (~bus.src1_i + 1'b1) : bus.src1_i;
    assign mag2      = src2_neg ? (~bus.src2_i + 1'b1) : bus.src2_i;

    // Restoring divide step: bring in the next dividend bit and try the
    // subtraction. The partial remainder is always below the divisor, so
    // the difference fits in WIDTH bits whenever the trial succeeds.
    assign div_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge      = div_shifted >= {1'b0, mplier_q};
    assign div_sub     = div_shifted[WIDTH-1:0] - mplier_q;

    assign quo_raw = acc_q[WIDTH-1:0];
    assign rem_raw = acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    // The current step consumes mplier_q[0]; if nothing is left above it,
    // the product is complete after this step.
    assign mul_early = (mplier_q[WIDTH-1:1] == '0);
`else
    assign mul_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.annul_i && bus.start_i) begin
                    is_div_d = bus.op_i[1];
                    // neg_lo: product / quotient sign, neg_hi: remainder sign
                    neg_lo_d = src1_neg ^ src2_neg;
                    neg_hi_d = src1_neg;
                    if (bus.op_i[1] && (bus.src2_i == '0)) begin
                        result_d = {bus.src1_i, {WIDTH{1'b1}}};
                        state_d  = S_DONE;
                    end else begin
                        cnt_d    = CNT_W'(WIDTH);
                        mplier_d = mag2;
                        if (bus.op_i[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, mag1};
                            mcand_d = '0;
                        end else begin
                            acc_d   = '0;
                            mcand_d = {{WIDTH{1'b0}}, mag1};
                        end
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (is_div_q) begin
                        acc_d = {div_ge ? div_sub : div_shifted[WIDTH-1:0],
                                 acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if ((cnt_q == CNT_W'(1)) || (!is_div_q && mul_early)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        result_d = {neg_hi_q ? (~rem_raw + 1'b1) : rem_raw,
                                    neg_lo_q ? (~quo_raw + 1'b1) : quo_raw};
                    end else begin
                        result_d = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy_o     = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.ready_o    = (state_q == S_DONE);
    assign bus.stallreq_o = bus.start_i & ~bus.ready_o;
    assign bus.result_o   = result_q;

endmodule
